// File: rtl/persiana_pkg.sv
// persiana_pkg
// Shared definitions for the automatic-blind plant emulator:
//   - persiana_st_t : plant state machine encoding
//   - *_DEF         : default geometry / timing parameters
//   - cnt_w()       : width of a counter that must hold 0..n-1 (at least 1 bit)
package persiana_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        BRAKE = 3'd3,
        FAULT = 3'd4
    } persiana_st_t;

    localparam int TRAVEL_DEF      = 64;
    localparam int MID_DEF         = 32;
    localparam int STEP_DIV_DEF    = 4;
    localparam int BRAKE_STEPS_DEF = 2;
    localparam int OVERRUN_DEF     = 8;

    // A counter of n pulses only ever holds 0..n-1; keep one bit minimum
    // so n = 1 still yields a legal vector.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/persiana_pos_cnt.sv
// persiana_pos_cnt
// Saturating up/down blind position counter with a sub-step divider.
// A position step happens on every STEP_DIV-th qualified pulse.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   clr_i         : clears the sub-step divider (held while not driving)
//   up_i / dn_i   : qualified step pulses in the raise / lower direction
//   pos_o         : current position, 0 = closed, TRAVEL = open
//   at_min_o      : pos_o == 0
//   at_mid_o      : pos_o == MID
//   at_max_o      : pos_o == TRAVEL
module persiana_pos_cnt
    import persiana_pkg::*;
#(
    parameter int TRAVEL   = TRAVEL_DEF,
    parameter int MID      = MID_DEF,
    parameter int STEP_DIV = STEP_DIV_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr_i,
    input  logic                        up_i,
    input  logic                        dn_i,
    output logic [$clog2(TRAVEL+1)-1:0] pos_o,
    output logic                        at_min_o,
    output logic                        at_mid_o,
    output logic                        at_max_o
);

    localparam int PW = $clog2(TRAVEL + 1);
    localparam int SW = cnt_w(STEP_DIV);

    localparam logic [PW-1:0] POS_MAX  = PW'(TRAVEL);
    localparam logic [PW-1:0] POS_MID  = PW'(MID);
    localparam logic [SW-1:0] SUB_LAST = SW'(STEP_DIV - 1);

    logic [PW-1:0] pos_q;
    logic [SW-1:0] sub_q;

    assign at_min_o = (pos_q == '0);
    assign at_mid_o = (pos_q == POS_MID);
    assign at_max_o = (pos_q == POS_MAX);
    assign pos_o    = pos_q;

    // Pulses aimed at a limit are not counted here; the overrun logic in
    // the parent owns that case, so the divider never advances at a limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= '0;
            sub_q <= '0;
        end else if (clr_i) begin
            sub_q <= '0;
        end else if (up_i && !at_max_o) begin
            if (sub_q == SUB_LAST) begin
                pos_q <= pos_q + PW'(1);
                sub_q <= '0;
            end else begin
                sub_q <= sub_q + SW'(1);
            end
        end else if (dn_i && !at_min_o) begin
            if (sub_q == SUB_LAST) begin
                pos_q <= pos_q - PW'(1);
                sub_q <= '0;
            end else begin
                sub_q <= sub_q + SW'(1);
            end
        end
    end

endmodule

// File: rtl/persiana_planta.sv
// persiana_planta
// Behavioural plant for the automatic blind: integrates subir/bajar motor
// commands into a position, generates the limit / mid sensors, and latches
// a fault on illegal drive (both directions, or pushing into a limit).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   step_en             : prescaler strobe; all motion timing counts these
//   subir / bajar       : raise / lower commands
//   fault_clr           : clears FAULT when no command is asserted
//   pos                 : blind position, 0 = closed
//   s_inf/s_med/s_sup   : pos == 0 / MID / TRAVEL
//   moving              : state is UP or DOWN
//   fault               : state is FAULT
module persiana_planta
    import persiana_pkg::*;
#(
    parameter int TRAVEL      = TRAVEL_DEF,
    parameter int MID         = MID_DEF,
    parameter int STEP_DIV    = STEP_DIV_DEF,
    parameter int BRAKE_STEPS = BRAKE_STEPS_DEF,
    parameter int OVERRUN     = OVERRUN_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        step_en,
    input  logic                        subir,
    input  logic                        bajar,
    input  logic                        fault_clr,
    output logic [$clog2(TRAVEL+1)-1:0] pos,
    output logic                        s_inf,
    output logic                        s_med,
    output logic                        s_sup,
    output logic                        moving,
    output logic                        fault
);

    localparam int OW = cnt_w(OVERRUN);
    localparam int BW = cnt_w(BRAKE_STEPS);

    localparam logic [OW-1:0] OV_LAST = OW'(OVERRUN - 1);
    localparam logic [BW-1:0] BR_LAST = BW'(BRAKE_STEPS - 1);

    persiana_st_t  state_q;
    logic [OW-1:0] ov_q;
    logic [BW-1:0] br_q;

    logic up_only;
    logic dn_only;
    logic both_cmd;
    logic drive_up;
    logic drive_dn;
    logic at_min;
    logic at_mid;
    logic at_max;

    assign up_only  = subir && !bajar;
    assign dn_only  = bajar && !subir;
    assign both_cmd = subir && bajar;

    // Driving only while staying in UP/DOWN with the matching single
    // command; any command that would change state also holds the divider
    // clear, so a coincident step_en never moves pos and every state
    // change leaves the sub-step count at zero.
    assign drive_up = (state_q == UP)   && up_only;
    assign drive_dn = (state_q == DOWN) && dn_only;

    persiana_pos_cnt #(
        .TRAVEL   (TRAVEL),
        .MID      (MID),
        .STEP_DIV (STEP_DIV)
    ) u_pos_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (!(drive_up || drive_dn)),
        .up_i     (drive_up && step_en),
        .dn_i     (drive_dn && step_en),
        .pos_o    (pos),
        .at_min_o (at_min),
        .at_mid_o (at_mid),
        .at_max_o (at_max)
    );

    assign s_inf  = at_min;
    assign s_med  = at_mid;
    assign s_sup  = at_max;
    assign moving = (state_q == UP) || (state_q == DOWN);
    assign fault  = (state_q == FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ov_q    <= '0;
            br_q    <= '0;
        end else if (both_cmd && (state_q != FAULT)) begin
            // Shorted drive wins over any step counting this cycle.
            state_q <= FAULT;
            ov_q    <= '0;
            br_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    ov_q <= '0;
                    br_q <= '0;
                    if (up_only) begin
                        state_q <= UP;
                    end else if (dn_only) begin
                        state_q <= DOWN;
                    end
                end
                UP: begin
                    if (dn_only) begin
                        state_q <= BRAKE;
                        ov_q    <= '0;
                    end else if (!subir) begin
                        state_q <= IDLE;
                        ov_q    <= '0;
                    end else if (!at_max) begin
                        ov_q <= '0;
                    end else if (step_en) begin
                        if (ov_q == OV_LAST) begin
                            state_q <= FAULT;
                            ov_q    <= '0;
                        end else begin
                            ov_q <= ov_q + OW'(1);
                        end
                    end
                end
                DOWN: begin
                    if (up_only) begin
                        state_q <= BRAKE;
                        ov_q    <= '0;
                    end else if (!bajar) begin
                        state_q <= IDLE;
                        ov_q    <= '0;
                    end else if (!at_min) begin
                        ov_q <= '0;
                    end else if (step_en) begin
                        if (ov_q == OV_LAST) begin
                            state_q <= FAULT;
                            ov_q    <= '0;
                        end else begin
                            ov_q <= ov_q + OW'(1);
                        end
                    end
                end
                BRAKE: begin
                    // Single commands are deliberately ignored here.
                    if (step_en) begin
                        if (br_q == BR_LAST) begin
                            state_q <= IDLE;
                            br_q    <= '0;
                        end else begin
                            br_q <= br_q + BW'(1);
                        end
                    end
                end
                FAULT: begin
                    ov_q <= '0;
                    br_q <= '0;
                    if (fault_clr && !subir && !bajar) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= FAULT;
                    ov_q    <= '0;
                    br_q    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_persiana_planta.sv
module tb_persiana_planta;

    logic       clk;
    logic       rst_n;
    logic       step_en;
    logic       subir;
    logic       bajar;
    logic       fault_clr;
    logic [6:0] pos;
    logic       s_inf;
    logic       s_med;
    logic       s_sup;
    logic       moving;
    logic       fault;

    int checks;
    int errors;

    persiana_planta dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_en   (step_en),
        .subir     (subir),
        .bajar     (bajar),
        .fault_clr (fault_clr),
        .pos       (pos),
        .s_inf     (s_inf),
        .s_med     (s_med),
        .s_sup     (s_sup),
        .moving    (moving),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with step_en = se; inputs change and outputs are read at negedge.
    task automatic cyc(input logic se);
        step_en = se;
        @(posedge clk);
        @(negedge clk);
        step_en = 1'b0;
    endtask

    task automatic do_reset();
        subir = 1'b0; bajar = 1'b0; fault_clr = 1'b0; step_en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; subir = 1'b0; bajar = 1'b0; fault_clr = 1'b0; step_en = 1'b0;
        #1;
        checks++;
        if (pos !== 7'd0 || s_inf !== 1'b1 || s_med !== 1'b0 || s_sup !== 1'b0 ||
            moving !== 1'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pos=%0d inf=%b med=%b sup=%b mov=%b flt=%b, need 0 1 0 0 0 0",
                     pos, s_inf, s_med, s_sup, moving, fault);
        end
        $display("reset: pos=%0d s_inf=%b fault=%b", pos, s_inf, fault);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_full_raise();
        do_reset();
        subir = 1'b1;
        cyc(1'b0);
        checks++;
        if (moving !== 1'b1) begin
            errors++;
            $display("FAIL raise_enter_up: moving=%b need 1", moving);
        end
        for (int i = 1; i <= 256; i++) begin
            cyc(1'b1);
            if (i == 3) begin
                checks++;
                if (s_inf !== 1'b1 || pos !== 7'd0) begin
                    errors++;
                    $display("FAIL raise_3_steps: pos=%0d s_inf=%b need 0 1", pos, s_inf);
                end
            end
            if (i == 4) begin
                checks++;
                if (s_inf !== 1'b0 || pos !== 7'd1) begin
                    errors++;
                    $display("FAIL raise_4_steps: pos=%0d s_inf=%b need 1 0", pos, s_inf);
                end
            end
            if (i == 127) begin
                checks++;
                if (s_med !== 1'b0 || pos !== 7'd31) begin
                    errors++;
                    $display("FAIL raise_127_steps: pos=%0d s_med=%b need 31 0", pos, s_med);
                end
            end
            if (i == 128) begin
                checks++;
                if (s_med !== 1'b1 || pos !== 7'd32) begin
                    errors++;
                    $display("FAIL raise_128_steps: pos=%0d s_med=%b need 32 1", pos, s_med);
                end
            end
            if (i == 255) begin
                checks++;
                if (s_sup !== 1'b0 || pos !== 7'd63) begin
                    errors++;
                    $display("FAIL raise_255_steps: pos=%0d s_sup=%b need 63 0", pos, s_sup);
                end
            end
        end
        checks++;
        if (s_sup !== 1'b1 || pos !== 7'd64 || s_med !== 1'b0) begin
            errors++;
            $display("FAIL raise_256_steps: pos=%0d s_sup=%b s_med=%b need 64 1 0", pos, s_sup, s_med);
        end
        $display("full_raise: pos=%0d s_sup=%b", pos, s_sup);
    endtask

    // Continues from the open limit reached by test_full_raise.
    task automatic test_overrun();
        for (int i = 1; i <= 7; i++) cyc(1'b1);
        checks++;
        if (fault !== 1'b0 || moving !== 1'b1 || pos !== 7'd64) begin
            errors++;
            $display("FAIL overrun_7: fault=%b moving=%b pos=%0d need 0 1 64", fault, moving, pos);
        end
        cyc(1'b1);
        checks++;
        if (fault !== 1'b1 || moving !== 1'b0 || pos !== 7'd64) begin
            errors++;
            $display("FAIL overrun_8: fault=%b moving=%b pos=%0d need 1 0 64", fault, moving, pos);
        end
        $display("overrun: fault=%b pos=%0d", fault, pos);
        subir = 1'b0;
        fault_clr = 1'b1;
        cyc(1'b0);
        fault_clr = 1'b0;
        checks++;
        if (fault !== 1'b0 || pos !== 7'd64) begin
            errors++;
            $display("FAIL overrun_clear: fault=%b pos=%0d need 0 64", fault, pos);
        end
    endtask

    task automatic test_reversal();
        do_reset();
        subir = 1'b1;
        cyc(1'b0);
        for (int i = 0; i < 40; i++) cyc(1'b1);
        checks++;
        if (pos !== 7'd10) begin
            errors++;
            $display("FAIL rev_start_pos: pos=%0d need 10", pos);
        end
        subir = 1'b0;
        bajar = 1'b1;
        cyc(1'b0);
        checks++;
        if (moving !== 1'b0 || pos !== 7'd10) begin
            errors++;
            $display("FAIL rev_brake_enter: moving=%b pos=%0d need 0 10", moving, pos);
        end
        cyc(1'b1);
        cyc(1'b0);
        // Still braking after one pulse: bajar must not start DOWN yet.
        checks++;
        if (moving !== 1'b0 || pos !== 7'd10) begin
            errors++;
            $display("FAIL rev_brake_hold: moving=%b pos=%0d need 0 10", moving, pos);
        end
        cyc(1'b1);
        checks++;
        if (moving !== 1'b0 || pos !== 7'd10) begin
            errors++;
            $display("FAIL rev_brake_done: moving=%b pos=%0d need 0 10", moving, pos);
        end
        cyc(1'b0);
        checks++;
        if (moving !== 1'b1) begin
            errors++;
            $display("FAIL rev_down_enter: moving=%b need 1", moving);
        end
        for (int i = 0; i < 3; i++) cyc(1'b1);
        checks++;
        if (pos !== 7'd10) begin
            errors++;
            $display("FAIL rev_down_3: pos=%0d need 10", pos);
        end
        cyc(1'b1);
        checks++;
        if (pos !== 7'd9) begin
            errors++;
            $display("FAIL rev_down_4: pos=%0d need 9", pos);
        end
        $display("reversal: pos=%0d moving=%b", pos, moving);
        bajar = 1'b0;
        cyc(1'b0);
    endtask

    task automatic test_illegal_drive();
        do_reset();
        subir = 1'b1;
        bajar = 1'b1;
        cyc(1'b0);
        subir = 1'b0;
        bajar = 1'b0;
        checks++;
        if (fault !== 1'b1 || moving !== 1'b0) begin
            errors++;
            $display("FAIL both_in_idle: fault=%b moving=%b need 1 0", fault, moving);
        end
        subir = 1'b1;
        fault_clr = 1'b1;
        cyc(1'b0);
        checks++;
        if (fault !== 1'b1) begin
            errors++;
            $display("FAIL clr_with_cmd: fault=%b need 1", fault);
        end
        subir = 1'b0;
        cyc(1'b0);
        fault_clr = 1'b0;
        checks++;
        if (fault !== 1'b0 || moving !== 1'b0) begin
            errors++;
            $display("FAIL clr_no_cmd: fault=%b moving=%b need 0 0", fault, moving);
        end
        // Both commands with a step_en on what would be the 4th pulse: no move.
        subir = 1'b1;
        cyc(1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1);
        bajar = 1'b1;
        cyc(1'b1);
        subir = 1'b0;
        bajar = 1'b0;
        checks++;
        if (fault !== 1'b1 || pos !== 7'd0) begin
            errors++;
            $display("FAIL both_in_up_prio: fault=%b pos=%0d need 1 0", fault, pos);
        end
        $display("illegal_drive: fault=%b pos=%0d", fault, pos);
    endtask

    task automatic test_down_limit();
        do_reset();
        bajar = 1'b1;
        cyc(1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b1);
        checks++;
        if (fault !== 1'b0 || moving !== 1'b1 || s_inf !== 1'b1) begin
            errors++;
            $display("FAIL down_overrun_7: fault=%b moving=%b s_inf=%b need 0 1 1", fault, moving, s_inf);
        end
        cyc(1'b1);
        checks++;
        if (fault !== 1'b1 || pos !== 7'd0) begin
            errors++;
            $display("FAIL down_overrun_8: fault=%b pos=%0d need 1 0", fault, pos);
        end
        $display("down_limit: fault=%b pos=%0d", fault, pos);
        bajar = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        subir = 1'b1;
        cyc(1'b0);
        for (int i = 0; i < 160; i++) cyc(1'b1);
        subir = 1'b0;
        cyc(1'b0);
        bajar = 1'b1;
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b1);
        checks++;
        if (pos !== 7'd40 || moving !== 1'b1) begin
            errors++;
            $display("FAIL areset_setup: pos=%0d moving=%b need 40 1", pos, moving);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pos !== 7'd0 || s_inf !== 1'b1 || moving !== 1'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: pos=%0d s_inf=%b moving=%b fault=%b need 0 1 0 0",
                     pos, s_inf, moving, fault);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bajar = 1'b0;
        subir = 1'b1;
        cyc(1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1);
        checks++;
        if (pos !== 7'd0) begin
            errors++;
            $display("FAIL areset_restart_3: pos=%0d need 0", pos);
        end
        cyc(1'b1);
        checks++;
        if (pos !== 7'd1) begin
            errors++;
            $display("FAIL areset_restart_4: pos=%0d need 1", pos);
        end
        $display("async_reset: pos=%0d", pos);
        subir = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        step_en = 1'b0;
        subir = 1'b0;
        bajar = 1'b0;
        fault_clr = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_raise();
        test_overrun();
        test_reversal();
        test_illegal_drive();
        test_down_limit();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
